// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: word type, round/window sizes, the K round
// constant ROM, the message-schedule small sigma functions and the working
// hash-state struct used by the round datapath.
package sha_pkg;

    typedef logic [31:0] word_t;

    localparam int ROUNDS = 64;
    localparam int WIN    = 16;

    // Working variables a..h of the compression rounds.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } hash_state_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    localparam word_t K [0:ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // sigma0 = ror7 ^ ror18 ^ shr3
    function automatic word_t ssig0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1 = ror17 ^ ror19 ^ shr10
    function automatic word_t ssig1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_sched_expand.sv
// Combinational schedule expansion: produces the word that enters the top of
// the 16-word window, W_{t+16} = s1(W_{t+14}) + W_{t+9} + s0(W_{t+1}) + W_t.
// Ports:
//   w0     in  32  W_t      (window[0])
//   w1     in  32  W_{t+1}  (window[1])
//   w9     in  32  W_{t+9}  (window[9])
//   w14    in  32  W_{t+14} (window[14])
//   w_next out 32  W_{t+16}
module sha_sched_expand
    import sha_pkg::*;
(
    input  word_t w0,
    input  word_t w1,
    input  word_t w9,
    input  word_t w14,
    output word_t w_next
);

    assign w_next = ssig1(w14) + w9 + ssig0(w1) + w0;

endmodule

// File: rtl/sha_msg_sched.sv
// SHA-256 message schedule generator. Takes one padded 512-bit block and
// streams W_0..W_63 with the matching K_t and round index, one word per
// accepted beat, under ready/valid back-pressure from the round pipeline.
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   load_valid in   1    block_i valid
//   load_ready out  1    block taken when load_valid && load_ready
//   block_i    in   512  padded block, M_0 in [511:480] ... M_15 in [31:0]
//   out_valid  out  1    w_o/k_o/t_o/last_o valid
//   out_ready  in   1    beat taken when out_valid && out_ready
//   w_o        out  32   W_t
//   k_o        out  32   K_t
//   t_o        out  6    round index t
//   last_o     out  1    high on the t == 63 beat
module sha_msg_sched
    import sha_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [511:0] block_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  w_o,
    output logic [31:0]  k_o,
    output logic [5:0]   t_o,
    output logic         last_o
);

    sched_state_t            state_q, state_d;
    logic [WIN-1:0][31:0]    win_q;
    logic [5:0]              t_q;
    word_t                   w_next;
    logic                    beat, last_beat, load;

    assign out_valid = (state_q == ST_RUN);
    assign beat      = out_valid && out_ready;
    assign last_beat = beat && (t_q == 6'd63);

    // The final accept frees the window, so a new block can slide in on the
    // same edge and its W_0 follows W_63 with no bubble.
    assign load_ready = (state_q == ST_IDLE) || last_beat;
    assign load       = load_valid && load_ready;

    // Outputs are registers or the ROM read by the registered index only;
    // out_ready never reaches w_o/k_o/t_o.
    assign w_o    = win_q[0];
    assign k_o    = K[t_q];
    assign t_o    = t_q;
    assign last_o = out_valid && (t_q == 6'd63);

    sha_sched_expand u_expand (
        .w0     (win_q[0]),
        .w1     (win_q[1]),
        .w9     (win_q[9]),
        .w14    (win_q[14]),
        .w_next (w_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load) state_d = ST_RUN;
            ST_RUN:  if (last_beat && !load) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                for (int i = 0; i < WIN; i++)
                    win_q[i] <= block_i[511-32*i -: 32];
                t_q <= '0;
            end else if (beat) begin
                for (int i = 0; i < WIN-1; i++)
                    win_q[i] <= win_q[i+1];
                win_q[WIN-1] <= w_next;
                // Leaving RUN after W_63: park the index at 0 rather than wrap.
                t_q <= last_beat ? 6'd0 : t_q + 6'd1;
            end
        end
    end

endmodule
